// File: rtl/mem_write_scoreboard.sv
// In-order checker for CPU data-memory writes: a queue of expected (addr,data)
// pairs is compared against observed writes while the checker is in RUN.
module mem_write_scoreboard #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 8,
  parameter int CNT_W       = 8,
  parameter int CYC_W       = 16,
  parameter int TIMEOUT     = 1000,
  parameter int STOP_ON_ERR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              exp_valid,
  input  logic [ADDR_W-1:0] exp_addr,
  input  logic [DATA_W-1:0] exp_data,
  output logic              exp_ready,
  input  logic              memWrite,
  input  logic [ADDR_W-1:0] memDataAddr,
  input  logic [DATA_W-1:0] memWriteData,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [CNT_W-1:0]  err_count,
  output logic [CNT_W-1:0]  match_count,
  output logic [CYC_W-1:0]  cycle_count,
  output logic [ADDR_W-1:0] first_bad_addr,
  output logic [DATA_W-1:0] first_bad_data,
  output logic [1:0]        fsm_state
);

  // Expected-entry handshake: an entry transfers on a rising edge where
  // exp_valid && exp_ready; exp_ready depends only on registered queue fill.
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FILL_FULL = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   FILL_ONE  = (PTR_W + 1)'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CYC_W-1:0] CYC_MAX   = {CYC_W{1'b1}};
  localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] q_addr [DEPTH];
  logic [DATA_W-1:0] q_data [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    fill;

  logic in_run, start_run, empty, push, pop, chk, head_eq;
  logic is_match, is_err, last_pop, hit_timeout;

  assign in_run      = (state == RUN);
  assign start_run   = start && !in_run;
  assign empty       = (fill == '0);
  assign exp_ready   = (fill != FILL_FULL);
  assign push        = exp_valid && exp_ready;
  assign chk         = in_run && memWrite;
  assign head_eq     = (q_addr[rd_ptr] == memDataAddr) && (q_data[rd_ptr] == memWriteData);
  assign pop         = chk && !empty;
  assign is_match    = pop && head_eq;
  assign is_err      = chk && !is_match;
  assign last_pop    = pop && !push && (fill == FILL_ONE);
  assign hit_timeout = in_run && (cycle_count == CYC_LAST);

  assign busy      = in_run;
  assign done      = (state == DONE);
  assign pass      = done && (err_count == '0) && !timeout && empty;
  assign fsm_state = state;

  // Storage needs no reset: fill/pointers define which slots are live.
  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr] <= exp_addr;
      q_data[wr_ptr] <= exp_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_count      <= '0;
      match_count    <= '0;
      cycle_count    <= '0;
      timeout        <= 1'b0;
      first_bad_addr <= '0;
      first_bad_data <= '0;
    end else if (start_run) begin
      err_count      <= '0;
      match_count    <= '0;
      cycle_count    <= '0;
      timeout        <= 1'b0;
      first_bad_addr <= '0;
      first_bad_data <= '0;
    end else if (in_run) begin
      if (cycle_count != CYC_MAX) cycle_count <= cycle_count + 1'b1;
      if (is_match && (match_count != CNT_MAX)) match_count <= match_count + 1'b1;
      if (is_err) begin
        // err_count never returns to zero once bumped, so zero means "no error yet"
        if (err_count == '0) begin
          first_bad_addr <= memDataAddr;
          first_bad_data <= memWriteData;
        end
        if (err_count != CNT_MAX) err_count <= err_count + 1'b1;
      end
      if (hit_timeout) timeout <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = RUN;
      RUN: begin
        if (hit_timeout || last_pop || ((STOP_ON_ERR != 0) && is_err))
          state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_write_scoreboard.sv
// Bench for mem_write_scoreboard: queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed literal results.
module tb_mem_write_scoreboard;

  localparam int DEPTH   = 8;
  localparam int CNT_W   = 2;
  localparam int CYC_W   = 16;
  localparam int TIMEOUT = 50;
  localparam int STOP    = 0;
  localparam int CNT_SAT = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        exp_valid = 1'b0;
  logic [31:0] exp_addr = '0;
  logic [31:0] exp_data = '0;
  logic        exp_ready;
  logic        memWrite = 1'b0;
  logic [31:0] memDataAddr = '0;
  logic [31:0] memWriteData = '0;
  logic        busy, done, pass, timeout;
  logic [CNT_W-1:0] err_count, match_count;
  logic [CYC_W-1:0] cycle_count;
  logic [31:0] first_bad_addr, first_bad_data;
  logic [1:0]  fsm_state;

  int vectors = 0;
  int miscompares = 0;

  mem_write_scoreboard #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .CNT_W(CNT_W), .CYC_W(CYC_W),
    .TIMEOUT(TIMEOUT), .STOP_ON_ERR(STOP)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .exp_valid(exp_valid), .exp_addr(exp_addr), .exp_data(exp_data), .exp_ready(exp_ready),
    .memWrite(memWrite), .memDataAddr(memDataAddr), .memWriteData(memWriteData),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .err_count(err_count), .match_count(match_count), .cycle_count(cycle_count),
    .first_bad_addr(first_bad_addr), .first_bad_data(first_bad_data), .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model: 0 idle, 1 run, 2 done
  int          m_state;
  logic [31:0] m_qa[$];
  logic [31:0] m_qd[$];
  int          m_err, m_match, m_cyc;
  bit          m_to;
  logic [31:0] m_fba, m_fbd;
  bit          m_pushed, m_last, m_errev;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_state = 0; m_qa.delete(); m_qd.delete();
      m_err = 0; m_match = 0; m_cyc = 0; m_to = 0; m_fba = 0; m_fbd = 0;
    end else begin
      m_pushed = exp_valid && (m_qa.size() < DEPTH);
      m_last = 0;
      m_errev = 0;
      if (m_state == 1) begin
        if (memWrite) begin
          if (m_qa.size() == 0) begin
            m_errev = 1;
          end else begin
            if (m_qa[0] == memDataAddr && m_qd[0] == memWriteData) begin
              if (m_match < CNT_SAT) m_match++;
            end else begin
              m_errev = 1;
            end
            m_last = (m_qa.size() == 1);
            void'(m_qa.pop_front());
            void'(m_qd.pop_front());
          end
        end
        if (m_errev) begin
          if (m_err == 0) begin m_fba = memDataAddr; m_fbd = memWriteData; end
          if (m_err < CNT_SAT) m_err++;
        end
        if (m_cyc == TIMEOUT - 1) begin m_to = 1; m_state = 2; end
        else if (m_last && !m_pushed) m_state = 2;
        else if (STOP != 0 && m_errev) m_state = 2;
        m_cyc++;
      end else if (start) begin
        m_state = 1; m_err = 0; m_match = 0; m_cyc = 0; m_to = 0; m_fba = 0; m_fbd = 0;
      end
      if (m_pushed) begin
        m_qa.push_back(exp_addr);
        m_qd.push_back(exp_data);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard compare on the falling edge
  always @(negedge clk) begin
    chk("busy", 64'(busy), 64'(m_state == 1));
    chk("done", 64'(done), 64'(m_state == 2));
    chk("pass", 64'(pass), 64'(m_state == 2 && m_err == 0 && !m_to && m_qa.size() == 0));
    chk("timeout", 64'(timeout), 64'(m_to));
    chk("exp_ready", 64'(exp_ready), 64'(m_qa.size() < DEPTH));
    chk("err_count", 64'(err_count), 64'(m_err));
    chk("match_count", 64'(match_count), 64'(m_match));
    chk("cycle_count", 64'(cycle_count), 64'(m_cyc));
    chk("first_bad_addr", 64'(first_bad_addr), 64'(m_fba));
    chk("first_bad_data", 64'(first_bad_data), 64'(m_fbd));
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d);
    exp_valid = 1'b1; exp_addr = a; exp_data = d;
    tick();
    exp_valid = 1'b0;
  endtask

  task automatic kick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    memWrite = 1'b1; memDataAddr = a; memWriteData = d;
    tick();
    memWrite = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin tick(); n++; end
    chk("wait_done", 64'(done), 64'(1));
  endtask

  initial begin
    #2;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_ready", 64'(exp_ready), 64'(1));
    chk("rst_err", 64'(err_count), 64'(0));
    tick();
    reset = 1'b1;

    // 1: single matching write on the 21st RUN cycle
    push(84, 7);
    kick();
    repeat (20) tick();
    wr(84, 7);
    chk("t1_done", 64'(done), 64'(1));
    chk("t1_pass", 64'(pass), 64'(1));
    chk("t1_match", 64'(match_count), 64'(1));
    chk("t1_cyc", 64'(cycle_count), 64'(21));

    // 2: data mismatch
    push(84, 7);
    kick();
    wr(84, 6);
    chk("t2_done", 64'(done), 64'(1));
    chk("t2_pass", 64'(pass), 64'(0));
    chk("t2_err", 64'(err_count), 64'(1));
    chk("t2_fba", 64'(first_bad_addr), 64'(84));
    chk("t2_fbd", 64'(first_bad_data), 64'(6));

    // 3: timeout with entry left queued
    push(80, 1);
    kick();
    wait_done(60);
    chk("t3_to", 64'(timeout), 64'(1));
    chk("t3_cyc", 64'(cycle_count), 64'(50));
    chk("t3_pass", 64'(pass), 64'(0));
    kick();
    wr(80, 1);
    chk("t3_drain_pass", 64'(pass), 64'(1));

    // 4: fill queue, ninth push refused, then drain (match saturates)
    exp_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      exp_addr = 32'(i * 4); exp_data = 32'(100 + i);
      tick();
      if (i == 7) chk("t4_full", 64'(exp_ready), 64'(0));
    end
    exp_valid = 1'b0;
    kick();
    wr(0, 100);
    chk("t4_freed", 64'(exp_ready), 64'(1));
    for (int i = 1; i < 8; i++) wr(32'(i * 4), 32'(100 + i));
    chk("t4_done", 64'(done), 64'(1));
    chk("t4_pass", 64'(pass), 64'(1));
    chk("t4_match_sat", 64'(match_count), 64'(3));

    // 5: one mismatch among three, checking continues
    push(0, 1); push(4, 2); push(8, 3);
    kick();
    wr(0, 1);
    wr(4, 9);
    chk("t5_busy", 64'(busy), 64'(1));
    wr(8, 3);
    chk("t5_done", 64'(done), 64'(1));
    chk("t5_err", 64'(err_count), 64'(1));
    chk("t5_match", 64'(match_count), 64'(2));
    chk("t5_fba", 64'(first_bad_addr), 64'(4));

    // 6: async reset mid-RUN discards queue and results
    push(12, 1); push(16, 2); push(20, 3);
    kick();
    tick(); tick();
    #1 reset = 1'b0;
    #1;
    chk("t6_busy", 64'(busy), 64'(0));
    chk("t6_cyc", 64'(cycle_count), 64'(0));
    chk("t6_ready", 64'(exp_ready), 64'(1));
    tick();
    reset = 1'b1;
    kick();
    wr(12, 1);
    chk("t6_err", 64'(err_count), 64'(1));
    wait_done(60);
    chk("t6_to", 64'(timeout), 64'(1));

    // 7: push into empty queue alongside a write -> unexpected
    kick();
    exp_valid = 1'b1; exp_addr = 40; exp_data = 5;
    memWrite = 1'b1; memDataAddr = 40; memWriteData = 5;
    tick();
    exp_valid = 1'b0;
    wr(40, 5);
    chk("t7_done", 64'(done), 64'(1));
    chk("t7_err", 64'(err_count), 64'(1));
    chk("t7_match", 64'(match_count), 64'(1));

    // 8: err saturation, start ignored in RUN, first_bad held
    kick();
    for (int i = 0; i < 4; i++) wr(32'(200 + i), 32'(i));
    kick();
    chk("t8_err_sat", 64'(err_count), 64'(3));
    chk("t8_fba", 64'(first_bad_addr), 64'(200));
    wait_done(60);
    chk("t8_cyc", 64'(cycle_count), 64'(50));

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
